// File: rtl/mario_pkg.sv
// Shared sprite constants and types for the Mario pixel path
// (sprite fetch, ROM_Mario and color_mapper).
package mario_pkg;
    localparam int unsigned SPRITE_W        = 16;
    localparam int unsigned SPRITE_H        = 16;
    localparam logic [3:0]  TRANSPARENT_IDX = 4'h0;

    typedef logic [3:0] palette_idx_t;
    typedef logic [7:0] sprite_addr_t;
endpackage

// File: rtl/sprite_hit_calc.sv
// Combinational sprite box hit test and ROM address generation with
// optional horizontal mirroring; shared by all 16x16 sprite fetchers.
module sprite_hit_calc
    import mario_pkg::*;
#(
    parameter int unsigned SCALE = 1
) (
    input  logic [9:0]   i_draw_x,
    input  logic [9:0]   i_draw_y,
    input  logic [9:0]   i_pos_x,
    input  logic [9:0]   i_pos_y,
    input  logic         i_flip,
    output logic         o_hit,
    output sprite_addr_t o_addr
);
    localparam int unsigned SHIFT = SCALE - 1;
    localparam logic [9:0]  BOX_W = 10'(SPRITE_W * SCALE);
    localparam logic [9:0]  BOX_H = 10'(SPRITE_H * SCALE);

    logic [10:0] w_dx;
    logic [10:0] w_dy;
    logic [3:0]  w_col;
    logic [3:0]  w_row;
    logic        w_hit_x;
    logic        w_hit_y;

    // 11-bit differences: bit 10 set means the pixel is left of / above the box.
    always_comb begin
        w_dx    = {1'b0, i_draw_x} - {1'b0, i_pos_x};
        w_dy    = {1'b0, i_draw_y} - {1'b0, i_pos_y};
        w_hit_x = !w_dx[10] && (w_dx[9:0] < BOX_W);
        w_hit_y = !w_dy[10] && (w_dy[9:0] < BOX_H);
        w_col   = w_dx[SHIFT +: 4];
        w_row   = w_dy[SHIFT +: 4];
        if (i_flip) begin
            w_col = 4'hF - w_col;
        end
        o_hit  = w_hit_x && w_hit_y;
        o_addr = {w_row, w_col};
    end
endmodule

// File: rtl/mario_sprite_fetch.sv
// Two-stage Mario sprite fetch: frame-latched position, ROM address stage,
// then palette/opacity stage feeding color_mapper.
module mario_sprite_fetch #(
    parameter int unsigned SCALE           = 1,
    parameter logic [3:0]  TRANSPARENT_IDX = mario_pkg::TRANSPARENT_IDX
) (
    input  logic       Clk,
    input  logic       Reset,
    input  logic       frame_start,
    input  logic       pix_en,
    input  logic [9:0] DrawX,
    input  logic [9:0] DrawY,
    input  logic [9:0] mario_x,
    input  logic [9:0] mario_y,
    input  logic       facing_left,
    output logic [7:0] rom_addr,
    input  logic [3:0] rom_data,
    output logic       Is_Mario,
    output logic [3:0] Mario_in
);
    import mario_pkg::*;

    logic [9:0]   r_px;
    logic [9:0]   r_py;
    logic         r_flip;
    logic         r_hit1;
    sprite_addr_t r_rom_addr;
    logic         r_is_mario;
    palette_idx_t r_mario_in;

    logic         w_hit;
    sprite_addr_t w_addr;

    sprite_hit_calc #(
        .SCALE(SCALE)
    ) u_hit (
        .i_draw_x(DrawX),
        .i_draw_y(DrawY),
        .i_pos_x (r_px),
        .i_pos_y (r_py),
        .i_flip  (r_flip),
        .o_hit   (w_hit),
        .o_addr  (w_addr)
    );

    // A strobe coinciding with frame_start still sees the previous latch.
    always_ff @(posedge Clk) begin
        if (Reset) begin
            r_px       <= '0;
            r_py       <= '0;
            r_flip     <= 1'b0;
            r_hit1     <= 1'b0;
            r_rom_addr <= '0;
            r_is_mario <= 1'b0;
            r_mario_in <= '0;
        end else begin
            if (frame_start) begin
                r_px   <= mario_x;
                r_py   <= mario_y;
                r_flip <= facing_left;
            end
            if (pix_en) begin
                r_rom_addr <= w_hit ? w_addr : '0;
                r_hit1     <= w_hit;
                r_is_mario <= r_hit1 && (rom_data != TRANSPARENT_IDX);
                r_mario_in <= r_hit1 ? rom_data : '0;
            end
        end
    end

    assign rom_addr = r_rom_addr;
    assign Is_Mario = r_is_mario;
    assign Mario_in = r_mario_in;

`ifndef SYNTHESIS
    a_pix_en_spacing: assert property (@(posedge Clk) disable iff (Reset) pix_en |=> !pix_en)
        else $error("pix_en asserted on consecutive cycles");
`endif
endmodule

// File: tb/tb_mario_sprite_fetch.sv
// Bench for mario_sprite_fetch at SCALE=1 and SCALE=2 against a per-pixel
// reference model of the sprite box, address and palette rules.
module tb_mario_sprite_fetch;
    logic Clk = 1'b0;
    always #5 Clk = ~Clk;

    logic       Reset = 1'b1;
    logic       frame_start = 1'b0;
    logic       pix_en = 1'b0;
    logic [9:0] DrawX = '0;
    logic [9:0] DrawY = '0;
    logic [9:0] mario_x = '0;
    logic [9:0] mario_y = '0;
    logic       facing_left = 1'b0;
    logic [7:0] rom_addr1, rom_addr2;
    logic [3:0] rom_data1, rom_data2, Mario_in1, Mario_in2;
    logic       Is_Mario1, Is_Mario2;
    logic [3:0] rom1 [256];
    logic [3:0] rom2 [256];

    int n_vec = 0;
    int n_err = 0;

    typedef struct { logic hit; logic [7:0] addr; } pix_t;
    typedef struct { logic [7:0] addr; logic is; logic [3:0] in; } exp_t;
    typedef struct { int x; int y; logic fs; logic [7:0] addr; logic is; logic [3:0] in; } vec_t;

    int   m_px, m_py;
    logic m_flip;
    pix_t prev1, prev2;

    mario_sprite_fetch #(.SCALE(1), .TRANSPARENT_IDX(4'h0)) u_dut1 (
        .Clk(Clk), .Reset(Reset), .frame_start(frame_start), .pix_en(pix_en),
        .DrawX(DrawX), .DrawY(DrawY), .mario_x(mario_x), .mario_y(mario_y),
        .facing_left(facing_left), .rom_addr(rom_addr1), .rom_data(rom_data1),
        .Is_Mario(Is_Mario1), .Mario_in(Mario_in1)
    );

    mario_sprite_fetch #(.SCALE(2), .TRANSPARENT_IDX(4'h0)) u_dut2 (
        .Clk(Clk), .Reset(Reset), .frame_start(frame_start), .pix_en(pix_en),
        .DrawX(DrawX), .DrawY(DrawY), .mario_x(mario_x), .mario_y(mario_y),
        .facing_left(facing_left), .rom_addr(rom_addr2), .rom_data(rom_data2),
        .Is_Mario(Is_Mario2), .Mario_in(Mario_in2)
    );

    // Synchronous ROMs, one-cycle read latency.
    always @(posedge Clk) begin
        rom_data1 <= rom1[rom_addr1];
        rom_data2 <= rom2[rom_addr2];
    end

    function automatic pix_t ref_pix(input int scale, input int x, input int y);
        pix_t p;
        int dx, dy, col, row;
        dx = x - m_px;
        dy = y - m_py;
        p.hit = (dx >= 0 && dx < 16 * scale && dy >= 0 && dy < 16 * scale);
        col = dx / scale;
        row = dy / scale;
        if (m_flip) col = 15 - col;
        p.addr = p.hit ? 8'(row * 16 + col) : 8'h00;
        return p;
    endfunction

    task automatic model_reset();
        m_px = 0; m_py = 0; m_flip = 1'b0;
        prev1.hit = 1'b0; prev1.addr = 8'h00;
        prev2.hit = 1'b0; prev2.addr = 8'h00;
    endtask

    // One pixel strobe followed by one idle cycle; returns expected outputs.
    task automatic strobe(input int x, input int y, input logic fs, output exp_t e1, output exp_t e2);
        pix_t p;
        @(negedge Clk);
        DrawX = 10'(x); DrawY = 10'(y); frame_start = fs; pix_en = 1'b1;
        @(posedge Clk); #1;
        pix_en = 1'b0; frame_start = 1'b0;
        e1.is = prev1.hit && (rom1[prev1.addr] != 4'h0);
        e1.in = prev1.hit ? rom1[prev1.addr] : 4'h0;
        e2.is = prev2.hit && (rom2[prev2.addr] != 4'h0);
        e2.in = prev2.hit ? rom2[prev2.addr] : 4'h0;
        p = ref_pix(1, x, y); e1.addr = p.addr; prev1 = p;
        p = ref_pix(2, x, y); e2.addr = p.addr; prev2 = p;
        if (fs) begin
            m_px = int'(mario_x); m_py = int'(mario_y); m_flip = facing_left;
        end
        @(posedge Clk); #1;
    endtask

    task automatic frame_latch();
        @(negedge Clk);
        frame_start = 1'b1;
        @(posedge Clk); #1;
        frame_start = 1'b0;
        m_px = int'(mario_x); m_py = int'(mario_y); m_flip = facing_left;
    endtask

    task automatic fill_rom(input logic [3:0] val);
        for (int i = 0; i < 256; i++) begin
            rom1[i] = val;
            rom2[i] = val;
        end
        @(posedge Clk); #1;
    endtask

    task automatic test_reset();
        Reset = 1'b1;
        repeat (3) @(posedge Clk);
        #1;
        n_vec++; if (rom_addr1 !== 8'h00) begin n_err++; $display("FAIL reset u1 rom_addr: got %h want 00", rom_addr1); end
        n_vec++; if (Is_Mario1 !== 1'b0) begin n_err++; $display("FAIL reset u1 Is_Mario: got %b want 0", Is_Mario1); end
        n_vec++; if (Mario_in1 !== 4'h0) begin n_err++; $display("FAIL reset u1 Mario_in: got %h want 0", Mario_in1); end
        n_vec++; if (rom_addr2 !== 8'h00) begin n_err++; $display("FAIL reset u2 rom_addr: got %h want 00", rom_addr2); end
        n_vec++; if (Is_Mario2 !== 1'b0) begin n_err++; $display("FAIL reset u2 Is_Mario: got %b want 0", Is_Mario2); end
        n_vec++; if (Mario_in2 !== 4'h0) begin n_err++; $display("FAIL reset u2 Mario_in: got %h want 0", Mario_in2); end
        @(negedge Clk);
        Reset = 1'b0;
        model_reset();
    endtask

    task automatic test_box_corners();
        vec_t v[4];
        exp_t e1, e2;
        fill_rom(4'h5);
        mario_x = 10'd100; mario_y = 10'd200; facing_left = 1'b0;
        frame_latch();
        v = '{'{100, 200, 1'b0, 8'h00, 1'b0, 4'h0}, '{115, 215, 1'b0, 8'hFF, 1'b1, 4'h5},
              '{0, 0, 1'b0, 8'h00, 1'b1, 4'h5},     '{0, 0, 1'b0, 8'h00, 1'b0, 4'h0}};
        for (int i = 0; i < 4; i++) begin
            strobe(v[i].x, v[i].y, v[i].fs, e1, e2);
            n_vec++; if (rom_addr1 !== v[i].addr) begin n_err++; $display("FAIL box[%0d] u1 rom_addr: got %h want %h", i, rom_addr1, v[i].addr); end
            n_vec++; if (Is_Mario1 !== v[i].is) begin n_err++; $display("FAIL box[%0d] u1 Is_Mario: got %b want %b", i, Is_Mario1, v[i].is); end
            n_vec++; if (Mario_in1 !== v[i].in) begin n_err++; $display("FAIL box[%0d] u1 Mario_in: got %h want %h", i, Mario_in1, v[i].in); end
            n_vec++; if (rom_addr2 !== e2.addr) begin n_err++; $display("FAIL box[%0d] u2 rom_addr: got %h want %h", i, rom_addr2, e2.addr); end
            n_vec++; if (Is_Mario2 !== e2.is) begin n_err++; $display("FAIL box[%0d] u2 Is_Mario: got %b want %b", i, Is_Mario2, e2.is); end
            n_vec++; if (Mario_in2 !== e2.in) begin n_err++; $display("FAIL box[%0d] u2 Mario_in: got %h want %h", i, Mario_in2, e2.in); end
        end
    endtask

    task automatic test_flip_transparency();
        vec_t v[7];
        exp_t e1, e2;
        mario_x = 10'd100; mario_y = 10'd200; facing_left = 1'b1;
        frame_latch();
        v = '{'{100, 203, 1'b0, 8'h3F, 1'b0, 4'h0}, '{116, 203, 1'b0, 8'h00, 1'b1, 4'h5},
              '{0, 0, 1'b0, 8'h00, 1'b0, 4'h0},     '{115, 203, 1'b0, 8'h30, 1'b0, 4'h0},
              '{0, 0, 1'b0, 8'h00, 1'b0, 4'h0},     '{100, 203, 1'b0, 8'h3F, 1'b0, 4'h0},
              '{0, 0, 1'b0, 8'h00, 1'b1, 4'h5}};
        for (int i = 0; i < 7; i++) begin
            if (i == 3) begin
                rom1[8'h30] = 4'h0;
                rom2[8'h30] = 4'h0;
                @(posedge Clk); #1;
            end
            strobe(v[i].x, v[i].y, v[i].fs, e1, e2);
            n_vec++; if (rom_addr1 !== v[i].addr) begin n_err++; $display("FAIL flip[%0d] u1 rom_addr: got %h want %h", i, rom_addr1, v[i].addr); end
            n_vec++; if (Is_Mario1 !== v[i].is) begin n_err++; $display("FAIL flip[%0d] u1 Is_Mario: got %b want %b", i, Is_Mario1, v[i].is); end
            n_vec++; if (Mario_in1 !== v[i].in) begin n_err++; $display("FAIL flip[%0d] u1 Mario_in: got %h want %h", i, Mario_in1, v[i].in); end
            n_vec++; if (rom_addr2 !== e2.addr) begin n_err++; $display("FAIL flip[%0d] u2 rom_addr: got %h want %h", i, rom_addr2, e2.addr); end
            n_vec++; if (Is_Mario2 !== e2.is) begin n_err++; $display("FAIL flip[%0d] u2 Is_Mario: got %b want %b", i, Is_Mario2, e2.is); end
            n_vec++; if (Mario_in2 !== e2.in) begin n_err++; $display("FAIL flip[%0d] u2 Mario_in: got %h want %h", i, Mario_in2, e2.in); end
        end
    endtask

    task automatic test_frame_latch();
        vec_t v[8];
        exp_t e1, e2;
        mario_x = 10'd100; mario_y = 10'd200; facing_left = 1'b0;
        frame_latch();
        mario_x = 10'd300;
        v = '{'{100, 200, 1'b0, 8'h00, 1'b0, 4'h0}, '{0, 0, 1'b0, 8'h00, 1'b1, 4'h5},
              '{100, 200, 1'b0, 8'h00, 1'b0, 4'h0}, '{300, 200, 1'b0, 8'h00, 1'b0, 4'h0},
              '{0, 0, 1'b0, 8'h00, 1'b1, 4'h5},     '{300, 201, 1'b1, 8'h10, 1'b0, 4'h0},
              '{300, 201, 1'b0, 8'h00, 1'b1, 4'h5}, '{500, 201, 1'b0, 8'h10, 1'b0, 4'h0}};
        for (int i = 0; i < 8; i++) begin
            if (i == 2) frame_latch();
            if (i == 5) mario_x = 10'd500;
            strobe(v[i].x, v[i].y, v[i].fs, e1, e2);
            n_vec++; if (rom_addr1 !== v[i].addr) begin n_err++; $display("FAIL latch[%0d] u1 rom_addr: got %h want %h", i, rom_addr1, v[i].addr); end
            n_vec++; if (Is_Mario1 !== v[i].is) begin n_err++; $display("FAIL latch[%0d] u1 Is_Mario: got %b want %b", i, Is_Mario1, v[i].is); end
            n_vec++; if (Mario_in1 !== v[i].in) begin n_err++; $display("FAIL latch[%0d] u1 Mario_in: got %h want %h", i, Mario_in1, v[i].in); end
            n_vec++; if (rom_addr2 !== e2.addr) begin n_err++; $display("FAIL latch[%0d] u2 rom_addr: got %h want %h", i, rom_addr2, e2.addr); end
            n_vec++; if (Is_Mario2 !== e2.is) begin n_err++; $display("FAIL latch[%0d] u2 Is_Mario: got %b want %b", i, Is_Mario2, e2.is); end
            n_vec++; if (Mario_in2 !== e2.in) begin n_err++; $display("FAIL latch[%0d] u2 Mario_in: got %h want %h", i, Mario_in2, e2.in); end
        end
    endtask

    task automatic test_wrap();
        vec_t v[3];
        exp_t e1, e2;
        mario_x = 10'd1015; mario_y = 10'd0; facing_left = 1'b0;
        frame_latch();
        v = '{'{1023, 0, 1'b0, 8'h08, 1'b1, 4'h5}, '{0, 0, 1'b0, 8'h00, 1'b1, 4'h5},
              '{0, 0, 1'b0, 8'h00, 1'b0, 4'h0}};
        for (int i = 0; i < 3; i++) begin
            strobe(v[i].x, v[i].y, v[i].fs, e1, e2);
            n_vec++; if (rom_addr1 !== v[i].addr) begin n_err++; $display("FAIL wrap[%0d] u1 rom_addr: got %h want %h", i, rom_addr1, v[i].addr); end
            n_vec++; if (Is_Mario1 !== v[i].is) begin n_err++; $display("FAIL wrap[%0d] u1 Is_Mario: got %b want %b", i, Is_Mario1, v[i].is); end
            n_vec++; if (Mario_in1 !== v[i].in) begin n_err++; $display("FAIL wrap[%0d] u1 Mario_in: got %h want %h", i, Mario_in1, v[i].in); end
            n_vec++; if (rom_addr2 !== e2.addr) begin n_err++; $display("FAIL wrap[%0d] u2 rom_addr: got %h want %h", i, rom_addr2, e2.addr); end
            n_vec++; if (Is_Mario2 !== e2.is) begin n_err++; $display("FAIL wrap[%0d] u2 Is_Mario: got %b want %b", i, Is_Mario2, e2.is); end
            n_vec++; if (Mario_in2 !== e2.in) begin n_err++; $display("FAIL wrap[%0d] u2 Mario_in: got %h want %h", i, Mario_in2, e2.in); end
        end
    endtask

    task automatic test_scale2();
        vec_t v[3];
        exp_t e1, e2;
        mario_x = 10'd100; mario_y = 10'd200; facing_left = 1'b0;
        frame_latch();
        v = '{'{131, 200, 1'b0, 8'h0F, 1'b0, 4'h0}, '{132, 200, 1'b0, 8'h00, 1'b1, 4'h5},
              '{0, 0, 1'b0, 8'h00, 1'b0, 4'h0}};
        for (int i = 0; i < 3; i++) begin
            strobe(v[i].x, v[i].y, v[i].fs, e1, e2);
            n_vec++; if (rom_addr2 !== v[i].addr) begin n_err++; $display("FAIL scale2[%0d] u2 rom_addr: got %h want %h", i, rom_addr2, v[i].addr); end
            n_vec++; if (Is_Mario2 !== v[i].is) begin n_err++; $display("FAIL scale2[%0d] u2 Is_Mario: got %b want %b", i, Is_Mario2, v[i].is); end
            n_vec++; if (Mario_in2 !== v[i].in) begin n_err++; $display("FAIL scale2[%0d] u2 Mario_in: got %h want %h", i, Mario_in2, v[i].in); end
            n_vec++; if (rom_addr1 !== e1.addr) begin n_err++; $display("FAIL scale2[%0d] u1 rom_addr: got %h want %h", i, rom_addr1, e1.addr); end
            n_vec++; if (Is_Mario1 !== e1.is) begin n_err++; $display("FAIL scale2[%0d] u1 Is_Mario: got %b want %b", i, Is_Mario1, e1.is); end
            n_vec++; if (Mario_in1 !== e1.in) begin n_err++; $display("FAIL scale2[%0d] u1 Mario_in: got %h want %h", i, Mario_in1, e1.in); end
        end
    endtask

    task automatic test_reset_midframe();
        vec_t v[2];
        exp_t e1, e2;
        strobe(100, 200, 1'b0, e1, e2);
        strobe(0, 0, 1'b0, e1, e2);
        n_vec++; if (Is_Mario1 !== 1'b1) begin n_err++; $display("FAIL rst_pre u1 Is_Mario: got %b want 1", Is_Mario1); end
        n_vec++; if (Mario_in1 !== 4'h5) begin n_err++; $display("FAIL rst_pre u1 Mario_in: got %h want 5", Mario_in1); end
        @(negedge Clk);
        Reset = 1'b1;
        @(posedge Clk); #1;
        n_vec++; if (Is_Mario1 !== 1'b0) begin n_err++; $display("FAIL rst_mid u1 Is_Mario: got %b want 0", Is_Mario1); end
        n_vec++; if (Mario_in1 !== 4'h0) begin n_err++; $display("FAIL rst_mid u1 Mario_in: got %h want 0", Mario_in1); end
        n_vec++; if (rom_addr1 !== 8'h00) begin n_err++; $display("FAIL rst_mid u1 rom_addr: got %h want 00", rom_addr1); end
        n_vec++; if (rom_addr2 !== 8'h00) begin n_err++; $display("FAIL rst_mid u2 rom_addr: got %h want 00", rom_addr2); end
        @(negedge Clk);
        Reset = 1'b0;
        model_reset();
        // mario_x is still 100 on the live input; only the latched (cleared) position may be used.
        v = '{'{5, 3, 1'b0, 8'h35, 1'b0, 4'h0}, '{0, 0, 1'b0, 8'h00, 1'b1, 4'h5}};
        for (int i = 0; i < 2; i++) begin
            strobe(v[i].x, v[i].y, v[i].fs, e1, e2);
            n_vec++; if (rom_addr1 !== v[i].addr) begin n_err++; $display("FAIL rst_post[%0d] u1 rom_addr: got %h want %h", i, rom_addr1, v[i].addr); end
            n_vec++; if (Is_Mario1 !== v[i].is) begin n_err++; $display("FAIL rst_post[%0d] u1 Is_Mario: got %b want %b", i, Is_Mario1, v[i].is); end
            n_vec++; if (Mario_in1 !== v[i].in) begin n_err++; $display("FAIL rst_post[%0d] u1 Mario_in: got %h want %h", i, Mario_in1, v[i].in); end
            n_vec++; if (rom_addr2 !== e2.addr) begin n_err++; $display("FAIL rst_post[%0d] u2 rom_addr: got %h want %h", i, rom_addr2, e2.addr); end
            n_vec++; if (Is_Mario2 !== e2.is) begin n_err++; $display("FAIL rst_post[%0d] u2 Is_Mario: got %b want %b", i, Is_Mario2, e2.is); end
            n_vec++; if (Mario_in2 !== e2.in) begin n_err++; $display("FAIL rst_post[%0d] u2 Mario_in: got %h want %h", i, Mario_in2, e2.in); end
        end
    endtask

    task automatic test_random();
        exp_t e1, e2;
        logic fs;
        int x, y;
        for (int i = 0; i < 256; i++) begin
            rom1[i] = ($urandom_range(0, 3) == 0) ? 4'h0 : 4'($urandom_range(1, 15));
            rom2[i] = ($urandom_range(0, 3) == 0) ? 4'h0 : 4'($urandom_range(1, 15));
        end
        @(posedge Clk); #1;
        for (int n = 0; n < 400; n++) begin
            fs = 1'b0;
            if ($urandom_range(0, 7) == 0) begin
                mario_x = 10'($urandom);
                mario_y = 10'($urandom);
                facing_left = 1'($urandom);
                fs = 1'($urandom);
            end
            x = (m_px + 1020 + int'($urandom_range(0, 40))) % 1024;
            y = (m_py + 1020 + int'($urandom_range(0, 40))) % 1024;
            strobe(x, y, fs, e1, e2);
            n_vec++; if (rom_addr1 !== e1.addr) begin n_err++; $display("FAIL rand[%0d] u1 rom_addr: got %h want %h", n, rom_addr1, e1.addr); end
            n_vec++; if (Is_Mario1 !== e1.is) begin n_err++; $display("FAIL rand[%0d] u1 Is_Mario: got %b want %b", n, Is_Mario1, e1.is); end
            n_vec++; if (Mario_in1 !== e1.in) begin n_err++; $display("FAIL rand[%0d] u1 Mario_in: got %h want %h", n, Mario_in1, e1.in); end
            n_vec++; if (rom_addr2 !== e2.addr) begin n_err++; $display("FAIL rand[%0d] u2 rom_addr: got %h want %h", n, rom_addr2, e2.addr); end
            n_vec++; if (Is_Mario2 !== e2.is) begin n_err++; $display("FAIL rand[%0d] u2 Is_Mario: got %b want %b", n, Is_Mario2, e2.is); end
            n_vec++; if (Mario_in2 !== e2.in) begin n_err++; $display("FAIL rand[%0d] u2 Mario_in: got %h want %h", n, Mario_in2, e2.in); end
            repeat ($urandom_range(0, 2)) @(posedge Clk);
            #1;
        end
    endtask

    initial begin
        for (int i = 0; i < 256; i++) begin
            rom1[i] = 4'h0;
            rom2[i] = 4'h0;
        end
        model_reset();
        test_reset();
        test_box_corners();
        test_flip_transparency();
        test_frame_latch();
        test_wrap();
        test_scale2();
        test_reset_midframe();
        test_random();
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not complete, got timeout want finish");
        $fatal(1, "watchdog expired");
    end
endmodule

// File: doc/mario_sprite_fetch.md
Name: mario_sprite_fetch

Overview:
- Pixel-pipeline stage directly upstream of color_mapper.
- For each VGA pixel (DrawX, DrawY), decides whether the pixel falls inside Mario's 16x16 sprite box.
- When it does, generates the 8-bit read address for ROM_Mario and returns the 4-bit palette index plus the Is_Mario flag to color_mapper.
- Sprite position and facing are latched once per frame, so the sprite never tears mid-frame.

Parameters:
- SCALE, 1: integer sprite magnification, 1 or 2. On-screen box is 16*SCALE square.
- TRANSPARENT_IDX, 4'h0: palette index treated as background.

Ports:
- Clk  input  1  system clock (50 MHz)
- Reset  input  1  synchronous, active-high reset
- frame_start  input  1  one-cycle pulse at start of vertical blank
- pix_en  input  1  pixel strobe; pipeline advances only when high
- DrawX  input  10  current pixel column
- DrawY  input  10  current pixel row
- mario_x  input  10  sprite top-left column, live value from game logic
- mario_y  input  10  sprite top-left row, live value from game logic
- facing_left  input  1  1 = mirror the sprite horizontally
- rom_addr  output  8  READ_ADDR to ROM_Mario, registered
- rom_data  input  4  DATA_OUT from ROM_Mario; synchronous ROM with 1-cycle read latency
- Is_Mario  output  1  pixel is opaque Mario
- Mario_in  output  4  palette index to color_mapper

Behaviour:
- Reset (checked on the Clk edge):
  - All outputs clear: rom_addr=0, Is_Mario=0, Mario_in=0.
  - Latched position px/py clear to 0; latched facing flip clears to 0.
  - Pipeline valid/hit flags clear to 0.
  - Reset asserted mid-frame blanks the output on the next edge. Outputs stay 0 until the first two pix_en strobes after reset release.
- Frame latch: on frame_start=1, px<=mario_x, py<=mario_y, flip<=facing_left.
  - If frame_start and pix_en are high in the same cycle, that pix_en uses the old latched values.
- Hit test (combinational, 11-bit arithmetic so no wrap):
  - hit = DrawX>=px && DrawX<px+16*SCALE && DrawY>=py && DrawY<py+16*SCALE.
  - Example: px=1015, SCALE=1 gives a box covering 1015..1030. DrawX=1023 hits; DrawX=0 does not.
- Address generation:
  - col=(DrawX-px)>>(SCALE-1), row=(DrawY-py)>>(SCALE-1), both 4 bits.
  - If flip, col=15-col.
  - addr={row,col}.
- Stage 1, on a Clk edge with pix_en=1:
  - rom_addr<=hit ? addr : 8'h00.
  - hit1<=hit.
  - rom_addr holds between strobes.
- Stage 2, on the next Clk edge with pix_en=1:
  - Is_Mario<=hit1 && rom_data!=TRANSPARENT_IDX.
  - Mario_in<=hit1 ? rom_data : 4'h0.
  - Outputs hold between strobes.
- Latency: 2 pix_en strobes from DrawX/DrawY to Is_Mario/Mario_in. color_mapper compensates for this.
- pix_en spacing:
  - Consecutive pix_en strobes must be at least 2 Clk cycles apart (VGA 25 MHz from 50 MHz).
  - The block carries a simulation-only assertion flagging back-to-back pix_en.
  - No output guarantee is made when the spacing is violated.
- DrawX/DrawY outside the 640x480 visible area are processed identically; blanking is color_mapper's job.

Decomposition:
- Shared package mario_pkg:
  - SPRITE_W=16, SPRITE_H=16, TRANSPARENT_IDX=4'h0.
  - typedef palette_idx_t (logic [3:0]).
  - typedef sprite_addr_t (logic [7:0]).
  - Reused by ROM_Mario and color_mapper.
- One sub-module, sprite_hit_calc: purely combinational hit test plus address/flip calculation, reused later for goomba and block sprites.
- Stage registers and frame latch stay in the top.

Test Plan:
- Box corners: SCALE=1; frame_start with mario_x=100, mario_y=200, facing_left=0; strobe DrawX=100, DrawY=200 -> rom_addr=8'h00. Then DrawX=115, DrawY=215 -> rom_addr=8'hFF. ROM model returns 4'h5 -> Is_Mario=1, Mario_in=5 two strobes after each pixel.
- Flip and edge: same position with facing_left=1; DrawX=100, DrawY=203 -> rom_addr=8'h3F. DrawX=116 -> Is_Mario=0, Mario_in=0.
- Transparency: hit pixel where rom_data=4'h0 -> Is_Mario=0, Mario_in=0.
- Frame latch: change mario_x to 300 mid-frame without frame_start -> DrawX=100 still hits. After frame_start, DrawX=100 misses and DrawX=300 hits. Also check frame_start coinciding with pix_en uses old position.
- Wrap and SCALE: mario_x=1015; DrawX=1023 hits, DrawX=0 misses. With SCALE=2, mario_x=100: DrawX=131 hits with col=15, DrawX=132 misses.
- Reset: assert Reset while Is_Mario=1 -> next edge Is_Mario=0, Mario_in=0, rom_addr=0, latched position 0. After release, outputs stay 0 until 2 strobes.
